tone_melody_sequencer: RTL
==========================

Name: tone_melody_sequencer

Overview:
Note-sequencing stage that sits directly upstream of the FM transmitter core. Steps through an internal C-major scale ROM at a fixed tempo and presents one phase increment per note to the downstream NCO/FM modulator. Also produces playback status: playing, melody_end, note_index and a note-change strobe. Supports enable, loop and pause control.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency; used to derive the phase increment constants.
CLOCKS_PER_16TH, 6_250_000, clock cycles per sixteenth note (120 BPM at default).
MELODY_LENGTH, 16, number of ROM entries played (1..16).
PHASE_W, 32, phase-increment width.
GAP_CLOCKS, 500_000, articulation silence at each note end (used only with the optional feature).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous reset, active-high.
enable  in  1  level; 1 = play, 0 = stop and return to idle.
loop  in  1  sampled at the end of the last note; 1 = restart at index 0.
pause  in  1  level; 1 = freeze the duration counter and all outputs.
phase_inc  out  PHASE_W  phase increment for the current note; 0 means silence.
note_strobe  out  1  1-cycle pulse on the cycle phase_inc takes a new note's value.
playing  out  1  high in the PLAY and GAP states.
melody_end  out  1  1-cycle pulse when the last note's duration expires.
note_index  out  5  current ROM index.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; phase_inc=0, note_strobe=0, playing=0, melody_end=0, note_index=0, counter=0.
- ROM entry format:
  - code[3:0]: 0=rest; 1..8 = C4 D4 E4 F4 G4 A4 B4 C5.
  - dur[1:0]: 0..3 maps to 1, 2, 4 or 8 sixteenths.
- ROM contents:
  - Indices 0-7: C4 D4 E4 F4 G4 A4 B4 C5.
  - Indices 8-15: C5 B4 A4 G4 F4 E4 D4 C4.
  - Duration is 2 sixteenths, except indices 7 and 15, which are 4 sixteenths.
- Phase increment constant: round(f_note * 2^PHASE_W / CLK_FREQ_HZ), computed at elaboration.
- Phase increment values at defaults: C4=22474, D4=25225, E4=28315, F4=29999, G4=33673, A4=37796, B4=42426, C5=44947. A rest gives 0.
- States: IDLE, PLAY, GAP (GAP exists only with the optional feature), DONE.
- IDLE -> PLAY when enable=1. The same edge loads index 0, phase_inc=ROM[0] and counter=dur*CLOCKS_PER_16TH-1, and pulses note_strobe. Latency from enable to valid phase_inc is 1 clock.
- PLAY: counter decrements once per clock while pause=0. When counter=0 and pause=0, the note ends:
  - If index < MELODY_LENGTH-1: index+1, load the new phase_inc and counter, pulse note_strobe. No dead cycle between notes.
  - If index = MELODY_LENGTH-1: pulse melody_end.
    - loop=1: index wraps to 0, ROM[0] is loaded and note_strobe pulses on the same edge.
    - loop=0: go to DONE, phase_inc=0, playing=0.
- DONE: hold until enable=0, then go to IDLE. DONE does not restart while enable stays high.
- enable=0 in any state: go to IDLE on the next edge, with phase_inc=0, index=0 and no melody_end pulse.
- pause=1: counter, state and all outputs hold. Strobes are not generated. enable=0 overrides pause.
- Rest notes: phase_inc=0 with playing=1. note_strobe still pulses.
- Counter width is ceil(log2(8*CLOCKS_PER_16TH)). All outputs are registered.

Optional Feature:
Macro SEQ_ARTIC_GAP_EN.
- Defined: each note's counter is loaded with dur*CLOCKS_PER_16TH-GAP_CLOCKS-1. At expiry the state goes to GAP with phase_inc=0 and playing=1 for GAP_CLOCKS cycles, then advances exactly as in PLAY. Total note period is unchanged. pause freezes the GAP counter as well.
- Undefined: the GAP state and GAP_CLOCKS logic are absent. Notes are legato, as described above.

Test Plan:
1. CLOCKS_PER_16TH=4, enable rises with loop=0 -> the next edge gives phase_inc=22474 and a note_strobe pulse. Thereafter, a new note every 8 clocks for indices 0-6 and every 16 clocks for index 7, in ROM order. melody_end pulses once after 144 clocks. Then DONE with phase_inc=0 and playing=0.
2. Same setup with loop=1 -> after index 15 expires, melody_end and note_strobe pulse on the same cycle, index=0, phase_inc=22474, and playing never drops.
3. enable deasserted mid-note at index 5 -> the next edge gives IDLE, phase_inc=0, index=0 and no melody_end. Re-enabling restarts at index 0.
4. pause=1 for 10 clocks during index 2 -> phase_inc holds at 28315 and no strobes occur. The note ends 10 clocks later than in scenario 1.
5. rst asserted asynchronously mid-note -> all outputs are 0 before the next clock edge. After release, the block stays IDLE until enable is seen.
6. SEQ_ARTIC_GAP_EN with CLOCKS_PER_16TH=4 and GAP_CLOCKS=2 -> each 8-clock note gives 6 clocks of tone then 2 clocks of phase_inc=0 with playing=1. Total melody length is still 144 clocks.

Source files
------------

// File: rtl/tone_melody_sequencer.sv
// Steps a C-major scale ROM at a fixed tempo and feeds one phase increment per note to the NCO.
// Build option: define SEQ_ARTIC_GAP_EN to insert a silent articulation gap at the end of every note.
module tone_melody_sequencer #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int CLOCKS_PER_16TH = 6_250_000,
    parameter int MELODY_LENGTH   = 16,
    parameter int PHASE_W         = 32
`ifdef SEQ_ARTIC_GAP_EN
    ,
    parameter int GAP_CLOCKS      = 500_000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               loop,
    input  logic               pause,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               note_strobe,
    output logic               playing,
    output logic               melody_end,
    output logic [4:0]         note_index
);

    localparam int         CNT_W    = $clog2(8 * CLOCKS_PER_16TH);
    localparam logic [4:0] LAST_IDX = 5'(MELODY_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
`ifdef SEQ_ARTIC_GAP_EN
        ,
        GAP  = 2'd3
`endif
    } state_t;

    // Rounded phase increment: round(f * 2^PHASE_W / CLK_FREQ_HZ), frequencies held in centi-hertz.
    function automatic logic [PHASE_W-1:0] note_inc(input logic [3:0] code);
        logic [63:0] centi_hz;
        logic [63:0] num;
        logic [63:0] den;
        case (code)
            4'd1:    centi_hz = 64'd26163;
            4'd2:    centi_hz = 64'd29366;
            4'd3:    centi_hz = 64'd32963;
            4'd4:    centi_hz = 64'd34923;
            4'd5:    centi_hz = 64'd39200;
            4'd6:    centi_hz = 64'd44000;
            4'd7:    centi_hz = 64'd49390;
            4'd8:    centi_hz = 64'd52325;
            default: centi_hz = 64'd0;
        endcase
        num = (centi_hz << PHASE_W) + 64'(CLK_FREQ_HZ) * 64'd50;
        den = 64'(CLK_FREQ_HZ) * 64'd100;
        return PHASE_W'(num / den);
    endfunction

    localparam logic [PHASE_W-1:0] INC_TABLE [16] = '{
        note_inc(4'd0),  note_inc(4'd1),  note_inc(4'd2),  note_inc(4'd3),
        note_inc(4'd4),  note_inc(4'd5),  note_inc(4'd6),  note_inc(4'd7),
        note_inc(4'd8),  note_inc(4'd9),  note_inc(4'd10), note_inc(4'd11),
        note_inc(4'd12), note_inc(4'd13), note_inc(4'd14), note_inc(4'd15)
    };

    // Entry layout {dur[1:0], code[3:0]}; dur 1 = two sixteenths, dur 2 = four.
    function automatic logic [5:0] rom_entry(input logic [4:0] idx);
        case (idx)
            5'd0:    rom_entry = {2'd1, 4'd1};
            5'd1:    rom_entry = {2'd1, 4'd2};
            5'd2:    rom_entry = {2'd1, 4'd3};
            5'd3:    rom_entry = {2'd1, 4'd4};
            5'd4:    rom_entry = {2'd1, 4'd5};
            5'd5:    rom_entry = {2'd1, 4'd6};
            5'd6:    rom_entry = {2'd1, 4'd7};
            5'd7:    rom_entry = {2'd2, 4'd8};
            5'd8:    rom_entry = {2'd1, 4'd8};
            5'd9:    rom_entry = {2'd1, 4'd7};
            5'd10:   rom_entry = {2'd1, 4'd6};
            5'd11:   rom_entry = {2'd1, 4'd5};
            5'd12:   rom_entry = {2'd1, 4'd4};
            5'd13:   rom_entry = {2'd1, 4'd3};
            5'd14:   rom_entry = {2'd1, 4'd2};
            5'd15:   rom_entry = {2'd2, 4'd1};
            default: rom_entry = {2'd0, 4'd0};
        endcase
    endfunction

    // Counter reload for a note; the gap build steals the articulation time from the tone.
    function automatic logic [CNT_W-1:0] dur_load(input logic [1:0] dur);
        int cycles;
        cycles = CLOCKS_PER_16TH << dur;
`ifdef SEQ_ARTIC_GAP_EN
        cycles = cycles - GAP_CLOCKS;
`endif
        return CNT_W'(cycles - 1);
    endfunction

    localparam logic [5:0] FIRST_ENTRY = rom_entry(5'd0);

    state_t             state, state_d;
    logic [CNT_W-1:0]   counter, counter_d;
    logic [4:0]         index_d;
    logic [PHASE_W-1:0] phase_d;
    logic               playing_d;
    logic               strobe_d;
    logic               mend_d;
    logic               advance;
    logic [4:0]         nxt_idx;
    logic [5:0]         nxt_entry;

    assign nxt_idx   = (note_index == LAST_IDX) ? 5'd0 : note_index + 5'd1;
    assign nxt_entry = rom_entry(nxt_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            note_index  <= '0;
            phase_inc   <= '0;
            playing     <= 1'b0;
            note_strobe <= 1'b0;
            melody_end  <= 1'b0;
        end else begin
            state       <= state_d;
            counter     <= counter_d;
            note_index  <= index_d;
            phase_inc   <= phase_d;
            playing     <= playing_d;
            note_strobe <= strobe_d;
            melody_end  <= mend_d;
        end
    end

    always_comb begin
        state_d   = state;
        counter_d = counter;
        index_d   = note_index;
        phase_d   = phase_inc;
        playing_d = playing;
        strobe_d  = 1'b0;
        mend_d    = 1'b0;
        advance   = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            counter_d = '0;
            index_d   = '0;
            phase_d   = '0;
            playing_d = 1'b0;
        end else if (!pause) begin
            case (state)
                IDLE: begin
                    state_d   = PLAY;
                    index_d   = 5'd0;
                    phase_d   = INC_TABLE[FIRST_ENTRY[3:0]];
                    counter_d = dur_load(FIRST_ENTRY[5:4]);
                    playing_d = 1'b1;
                    strobe_d  = 1'b1;
                end
                PLAY: begin
                    if (counter != '0) begin
                        counter_d = counter - CNT_W'(1);
                    end else begin
`ifdef SEQ_ARTIC_GAP_EN
                        state_d   = GAP;
                        counter_d = CNT_W'(GAP_CLOCKS - 1);
                        phase_d   = '0;
`else
                        advance   = 1'b1;
`endif
                    end
                end
`ifdef SEQ_ARTIC_GAP_EN
                GAP: begin
                    if (counter != '0) counter_d = counter - CNT_W'(1);
                    else               advance   = 1'b1;
                end
`endif
                DONE: begin
                end
                default: state_d = IDLE;
            endcase

            // Note boundary: step to the next entry, wrap on loop, or finish.
            if (advance) begin
                if (note_index == LAST_IDX) mend_d = 1'b1;
                if (note_index == LAST_IDX && !loop) begin
                    state_d   = DONE;
                    counter_d = '0;
                    phase_d   = '0;
                    playing_d = 1'b0;
                end else begin
                    state_d   = PLAY;
                    index_d   = nxt_idx;
                    phase_d   = INC_TABLE[nxt_entry[3:0]];
                    counter_d = dur_load(nxt_entry[5:4]);
                    playing_d = 1'b1;
                    strobe_d  = 1'b1;
                end
            end
        end
    end

endmodule
